// File: rtl/mips_bus_ram_slave.sv
// Word-addressed RAM slave for the mips_cpu_bus memory port, with waitrequest stalls.
// Define RAM_RANDOM_WAIT_EN to draw per-transfer wait counts from an 8-bit LFSR instead of WAIT_CYCLES.
module mips_bus_ram_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        write,
   input  logic        read,
   output logic        waitrequest,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        bus_error
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = 4;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n, wait_n;
   logic            req, both, idle_addr, valid, accept;
   logic [29:0]     word_off;
   logic [AW-1:0]   idx;
   logic [31:0]     mem [DEPTH_WORDS];

   // Memory power-up image; contents deliberately survive reset.
   initial begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] = 32'h0;
   end

   assign req       = read ^ write;
   assign both      = read & write;
   assign idle_addr = (address == 32'h0);
   assign word_off  = 30'((address - BASE_ADDR) >> 2);
   assign idx       = word_off[AW-1:0];
   assign valid     = (address >= BASE_ADDR) && (word_off < 30'(DEPTH_WORDS))
                      && (address[1:0] == 2'b00);

`ifdef RAM_RANDOM_WAIT_EN
   logic [7:0] lfsr;

   // Fibonacci LFSR, taps 8,6,5,4; steps once per accepted transfer.
   always_ff @(posedge clk) begin
      if (reset)       lfsr <= 8'hA5;
      else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign wait_n = {2'b00, lfsr[1:0]};
`else
   assign wait_n = CW'(WAIT_CYCLES);
`endif

   // Wait-state sequencing; the idle address 0 bypasses stalls entirely.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      waitrequest = 1'b0;
      accept      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               if (idle_addr || (wait_n == '0)) begin
                  accept = 1'b1;
               end else begin
                  waitrequest = 1'b1;
                  cnt_n       = CW'(1);
                  state_n     = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end else if (!idle_addr && (cnt < wait_n)) begin
               waitrequest = 1'b1;
               cnt_n       = CW'(cnt + CW'(1));
            end else begin
               accept  = 1'b1;
               cnt_n   = '0;
               state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         readdata  <= 32'h0;
         bus_error <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (both) bus_error <= 1'b1;
         if (accept && !idle_addr && !valid) bus_error <= 1'b1;
         if (accept && read) begin
            if (!idle_addr && valid) readdata <= mem[idx];
            else                     readdata <= 32'h0;
         end
      end
   end

   // Byte-lane writes; out-of-range and idle-address writes are dropped.
   always_ff @(posedge clk) begin
      if (!reset && accept && write && !idle_addr && valid) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mips_bus_ram_slave.sv
// Directed bench for mips_bus_ram_slave: wait states, byte enables, idle address, errors, aborts.
module tb_mips_bus_ram_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic        write;
   logic        read;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        bus_error;

   int tests = 0;
   int fails = 0;
   logic [7:0] lfsr_m;

   mips_bus_ram_slave dut (
      .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
      .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
      .readdata(readdata), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fail_msg(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      lfsr_m = 8'hA5;
   endtask

   // One bus transfer; checks the stall count against the expected wait count.
   task automatic xfer(input string tag, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int waits;
      int exp_w;
`ifdef RAM_RANDOM_WAIT_EN
      exp_w = (a == 32'h0) ? 0 : int'(lfsr_m[1:0]);
`else
      exp_w = (a == 32'h0) ? 0 : 2;
`endif
      read = r; write = w; address = a; writedata = d; byteenable = be;
      waits = 0;
      @(negedge clk);
      while (waitrequest && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      check(tag, 32'(waits), 32'(exp_w));
      @(posedge clk);
      #1 read = 1'b0; write = 1'b0;
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
      xfer(tag, 1'b0, 1'b1, a, d, be);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      xfer(tag, 1'b1, 1'b0, a, 32'h0, 4'h0);
      check(tag, readdata, exp);
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; address = 32'h0;
      writedata = 32'h0; byteenable = 4'h0;
      lfsr_m = 8'hA5;
      do_reset();
      @(negedge clk);
      tests++;
      if (readdata !== 32'h0) fail_msg("rst_readdata", readdata, 32'h0);
      tests++;
      if (bus_error !== 1'b0) fail_msg("rst_bus_error", 32'(bus_error), 32'h0);
      tests++;
      if (waitrequest !== 1'b0) fail_msg("rst_waitreq", 32'(waitrequest), 32'h0);
      @(posedge clk); #1;

      // Preload and basic wait-state read
      wr("wr_w0", 32'hBFC00000, 32'h3C08BFC0, 4'hF);
      wr("wr_w12", 32'hBFC00030, 32'h0000000F, 4'hF);
      rd_chk("rd_w0", 32'hBFC00000, 32'h3C08BFC0);

      // Single byte lane
      wr("wr_be", 32'hBFC00030, 32'h0000AB00, 4'b0010);
      rd_chk("rd_be", 32'hBFC00030, 32'h0000AB0F);

      // Full word with neighbours
      wr("wr_w2", 32'hBFC00008, 32'h11111111, 4'hF);
      wr("wr_w1", 32'hBFC00004, 32'hDEADBEEF, 4'hF);
      tests++;
      if (readdata !== 32'h0000AB0F) fail_msg("rd_hold_after_wr", readdata, 32'h0000AB0F);
      rd_chk("rd_w1", 32'hBFC00004, 32'hDEADBEEF);
      rd_chk("rd_w0_nb", 32'hBFC00000, 32'h3C08BFC0);
      rd_chk("rd_w2_nb", 32'hBFC00008, 32'h11111111);

      // byteenable 0000 is a no-op
      wr("wr_be0", 32'hBFC00004, 32'h00000000, 4'h0);
      rd_chk("rd_be0", 32'hBFC00004, 32'hDEADBEEF);

      // Idle address
      rd_chk("rd_idle", 32'h0, 32'h0);
      tests++;
      if (bus_error !== 1'b0) fail_msg("idle_no_err", 32'(bus_error), 32'h0);

      // Out-of-range write must not wrap onto word 0
      wr("wr_oor", 32'hBFC00100, 32'h12345678, 4'hF);
      tests++;
      if (bus_error !== 1'b1) fail_msg("oor_err", 32'(bus_error), 32'h1);
      rd_chk("rd_after_oor", 32'hBFC00000, 32'h3C08BFC0);
      do_reset();
      @(negedge clk);
      tests++;
      if (bus_error !== 1'b0) fail_msg("err_cleared", 32'(bus_error), 32'h0);
      tests++;
      if (readdata !== 32'h0) fail_msg("rst_rd_cleared", readdata, 32'h0);
      @(posedge clk); #1;
      rd_chk("retained", 32'hBFC00000, 32'h3C08BFC0);

      // Unaligned and below-base reads
      rd_chk("rd_unaligned", 32'hBFC00002, 32'h0);
      tests++;
      if (bus_error !== 1'b1) fail_msg("unaligned_err", 32'(bus_error), 32'h1);
      do_reset();
      rd_chk("rd_below", 32'hBFBFFFFC, 32'h0);
      tests++;
      if (bus_error !== 1'b1) fail_msg("below_err", 32'(bus_error), 32'h1);
      do_reset();

      // Read and write together
      rd_chk("rd_pre_both", 32'hBFC00004, 32'hDEADBEEF);
      read = 1'b1; write = 1'b1; address = 32'hBFC00004;
      writedata = 32'h0BADF00D; byteenable = 4'hF;
      @(negedge clk);
      tests++;
      if (waitrequest !== 1'b0) fail_msg("both_waitreq", 32'(waitrequest), 32'h0);
      @(posedge clk); #1 read = 1'b0; write = 1'b0;
      tests++;
      if (bus_error !== 1'b1) fail_msg("both_err", 32'(bus_error), 32'h1);
      tests++;
      if (readdata !== 32'hDEADBEEF) fail_msg("both_rd_hold", readdata, 32'hDEADBEEF);
      do_reset();
      rd_chk("both_mem", 32'hBFC00004, 32'hDEADBEEF);

`ifndef RAM_RANDOM_WAIT_EN
      // Abort after one stall, then reissue for a full wait again
      read = 1'b1; address = 32'hBFC00008;
      @(negedge clk);
      tests++;
      if (waitrequest !== 1'b1) fail_msg("abort_wr", 32'(waitrequest), 32'h1);
      @(posedge clk); #1 read = 1'b0;
      @(posedge clk); #1;
      rd_chk("reissue", 32'hBFC00008, 32'h11111111);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
